ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Instruction sequencer: accepts one instruction at a time, decodes it into
// literal/ALU/stack strobes, and tracks a bounded stack pointer with a sticky fault.
module ctrl_seq #(
    parameter int IW  = 18,
    parameter int OPW = 5,
    parameter int JW  = 6,
    parameter int SPW = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [0:IW-1]  i_instr,
    input  logic           i_valid,
    output logic           o_ready,
    output logic [IW-3:0]  o_lit,
    output logic           o_litValid,
    output logic           o_RWCtrl,
    output logic           o_carryWCtrl,
    output logic [OPW-1:0] o_instrOP,
    output logic [JW-1:0]  o_jCtrl,
    output logic           o_stkWCtrl,
    output logic [SPW-1:0] o_sp,
    output logic           o_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [SPW-1:0] SP_MAX = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [0:IW-1]   r_instr;
    logic [0:IW-1]   w_instr_nxt;
    logic [SPW-1:0]  r_sp;
    logic [SPW-1:0]  w_sp_nxt;

    // Class of the incoming word (for the accept decision) and of the held word.
    logic w_in_push;
    logic w_in_pop;
    logic w_in_bad;
    logic w_is_lit;
    logic w_is_push;
    logic w_is_pop;
    logic w_need_wb;

    assign w_in_push = (i_instr[0:1] == 2'b10);
    assign w_in_pop  = (i_instr[0:1] == 2'b01);
    assign w_in_bad  = (w_in_push && (r_sp == SP_MAX)) ||
                       (w_in_pop  && (r_sp == '0));

    assign w_is_lit  = (r_instr[0:1] == 2'b00);
    assign w_is_push = (r_instr[0:1] == 2'b10);
    assign w_is_pop  = (r_instr[0:1] == 2'b01);
    assign w_need_wb = !w_is_lit && !r_instr[2] && r_instr[5];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_sp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_sp    <= w_sp_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_instr_nxt  = r_instr;
        w_sp_nxt     = r_sp;
        o_ready      = 1'b0;
        o_lit        = '0;
        o_litValid   = 1'b0;
        o_RWCtrl     = 1'b0;
        o_carryWCtrl = 1'b0;
        o_instrOP    = '0;
        o_jCtrl      = '0;
        o_stkWCtrl   = 1'b0;
        o_fault      = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_instr_nxt = i_instr;
                    w_state_nxt = w_in_bad ? S_FAULT : S_EXEC;
                end
            end

            S_EXEC: begin
                if (w_is_lit) begin
                    o_litValid = 1'b1;
                    o_lit      = r_instr[2:IW-1];
                end else begin
                    o_carryWCtrl = r_instr[2];
                    o_RWCtrl     = r_instr[2] | r_instr[6];
                    o_instrOP    = r_instr[3:3+OPW-1];
                    o_jCtrl      = r_instr[IW-JW:IW-1];
                end
                // Bounds were checked at accept; the guards keep sp from wrapping regardless.
                if (w_is_push && (r_sp != SP_MAX)) begin
                    w_sp_nxt = r_sp + 1'b1;
                end else if (w_is_pop && (r_sp != '0)) begin
                    w_sp_nxt = r_sp - 1'b1;
                end
                w_state_nxt = w_need_wb ? S_WB : S_IDLE;
            end

            S_WB: begin
                o_stkWCtrl  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            S_FAULT: begin
                o_fault = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_sp = r_sp;

endmodule
